// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory with reset-time initialisation.
// Holds the sequencer state enum, the power-on pattern function and default sizes.
// Optional build macro used by the top level: DMEM_ASYNC_READ_EN.
package dmem_pkg;

  localparam int DMEM_DATA_WIDTH = 8;
  localparam int DMEM_ADDR_WIDTH = 8;
  localparam int DMEM_DEPTH      = 32;
  // Widest word the pattern helper can produce.
  localparam int DMEM_MAX_DATA_W = 64;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dmem_state_t;

  // Lower half of the array counts up from 0, upper half counts down from 0
  // (0, -1, -2, ...) in two's complement, masked to the word width.
  function automatic logic [DMEM_MAX_DATA_W-1:0] init_pattern(input int idx,
                                                              input int depth,
                                                              input int width);
    logic [DMEM_MAX_DATA_W-1:0] v;
    logic [DMEM_MAX_DATA_W-1:0] mask;
    int h;
    h = depth / 2;
    if (idx < h) v = DMEM_MAX_DATA_W'(idx);
    else         v = -(DMEM_MAX_DATA_W'(idx - h));
    if (width >= DMEM_MAX_DATA_W) mask = '1;
    else                          mask = (DMEM_MAX_DATA_W'(1) << width) - DMEM_MAX_DATA_W'(1);
    return v & mask;
  endfunction

endpackage

// File: rtl/dmem_init_seq.sv
// Initialisation sequencer: walks entries 0..DEPTH-1 after reset, one per cycle.
// Latency: ready rises DEPTH cycles after reset release.
// Reset at any time restarts the walk from entry 0.
module dmem_init_seq
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_we,
  output logic [IDX_W-1:0]      init_idx,
  output logic [DATA_WIDTH-1:0] init_data,
  output logic                  ready
);

  dmem_state_t      state;
  logic [IDX_W-1:0] cnt;

  // FSM: INIT counts through the array, RUN holds until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == IDX_W'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // A reset edge never writes the array, even while in INIT.
  assign init_we  = (state == INIT) && !reset;
  assign init_idx = cnt;

  // Pattern value for the entry currently being written.
  always_comb begin
    init_data = DATA_WIDTH'(init_pattern(int'(cnt), DEPTH, DATA_WIDTH));
  end

endmodule

// File: rtl/data_memory_init.sv
// Single-port data memory, synchronous write, registered read (async read with DMEM_ASYNC_READ_EN).
// Latency: read data valid one cycle after the read strobe; writes are write-first.
// While initialising (ready low) user accesses are ignored and writes flagged via write_dropped.
module data_memory_init
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DEPTH      = DMEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] data_inputs,
  output logic [DATA_WIDTH-1:0] data_outputs,
  output logic                  ready,
  output logic                  write_dropped
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      idx;
  logic                  init_we;
  logic [IDX_W-1:0]      init_idx;
  logic [DATA_WIDTH-1:0] init_data;
  logic                  user_we;

  // Upper address bits alias onto the array.
  assign idx     = address[IDX_W-1:0];
  assign user_we = ready && write && !reset;

  dmem_init_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .init_we   (init_we),
    .init_idx  (init_idx),
    .init_data (init_data),
    .ready     (ready)
  );

  // Array write port: sequencer owns it during INIT, user port in RUN.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_idx] <= init_data;
    end else if (user_we) begin
      mem[idx] <= data_inputs;
    end
  end

  // Flag user writes that land while the array is still being initialised.
  always_ff @(posedge clk) begin
    if (reset) write_dropped <= 1'b0;
    else       write_dropped <= write && !ready;
  end

`ifdef DMEM_ASYNC_READ_EN
  // Legacy combinational read; a same-cycle write shows up after the edge.
  assign data_outputs = ready ? mem[idx] : '0;

  logic unused_read;
  assign unused_read = read;
`else
  // Registered read, write-first on a same-index write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_outputs <= '0;
    end else if (ready && read) begin
      data_outputs <= write ? data_inputs : mem[idx];
    end
  end
`endif

  generate
    if (ADDR_WIDTH > IDX_W) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^address[ADDR_WIDTH-1:IDX_W];
    end
  endgenerate

endmodule

// File: doc/data_memory_init.md
# data_memory_init

Parametrised single-port data memory with a built-in reset-initialisation sequencer. It is the next generation of the processor's 8-bit, 32-entry data memory: width and depth are parameters, writes are synchronous, and reads are registered by default. A synchronous reset walks the array and loads a fixed power-on pattern, one entry per cycle. The block sits between the datapath's ALU/address path and the register-file write-back mux.

## Interface
Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 8: width of the `address` port.
- DEPTH, 32: number of entries.
  - Must be a power of two, ≥ 2 and ≤ 2^ADDR_WIDTH.
  - IDX_W = clog2(DEPTH).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset; starts initialisation.
- address  in  ADDR_WIDTH  word address; only the low IDX_W bits index the array, upper bits are ignored (aliasing).
- write  in  1  write strobe, sampled at the rising edge.
- read  in  1  read strobe, sampled at the rising edge; ignored in async-read build.
- data_inputs  in  DATA_WIDTH  write data.
- data_outputs  out  DATA_WIDTH  read data.
- ready  out  1  high when the array is initialised and accepts accesses.
- write_dropped  out  1  one-cycle pulse when `write` is high while `ready` is low.

## Operation
- Init pattern: idx = entry index, H = DEPTH/2.
  - Entry idx < H gets idx.
  - Entry idx ≥ H gets -(idx-H), two's complement truncated to DATA_WIDTH.
  - Default values: entries 0..15 = 0x00..0x0F; entries 16..31 = 0x00, 0xFF, 0xFE … 0xF1.
- States: INIT, RUN.
- Reset (any state, any cycle):
  - state <= INIT, init counter <= 0.
  - ready <= 0, data_outputs <= 0, write_dropped <= 0.
  - No array write occurs on a reset edge.
- INIT, reset low:
  - Each edge writes mem[cnt] <= pattern(cnt), then cnt <= cnt+1.
  - On the edge that writes cnt = DEPTH-1: state <= RUN, ready <= 1.
- In INIT, user `write` and `read` are ignored.
  - Array contents are unchanged by user writes.
  - data_outputs stays 0.
  - write_dropped <= write on every INIT edge.
- RUN:
  - write=1: mem[address[IDX_W-1:0]] <= data_inputs.
  - read=1: data_outputs <= mem[index].
  - Read and write to the same index in the same cycle: write-first, so data_outputs gets data_inputs.
  - read=0: data_outputs holds its value.
  - write_dropped <= 0.
- Reset asserted mid-INIT or in RUN restarts initialisation from entry 0. Prior user writes are overwritten by the pattern.

## Timing
- Reset sampled high at edge E0; reset low from edge E1 onward.
- Edges E1..E_DEPTH write entries 0..DEPTH-1.
- ready is high after E_DEPTH (DEPTH cycles after reset release). It rises 32 cycles after reset release at default DEPTH = 32.
- Holding reset high holds the counter at 0 indefinitely.
- Read latency: 1 cycle (strobe at edge N, data valid after edge N).
- Write latency: a write at edge N is visible to a read at edge N (write-first) and to every later read.
- write_dropped is registered: it is high for exactly the cycle after the dropped write edge.

## Configuration
- DMEM_ASYNC_READ_EN, when defined:
  - data_outputs = ready ? mem[address[IDX_W-1:0]] : 0, purely combinational, matching the legacy block's read behaviour.
  - `read` is unused.
  - A same-cycle write becomes visible after the edge.
- DMEM_ASYNC_READ_EN, when undefined: registered read as described above (default build).

## Structure
- Package dmem_pkg holds:
  - the state enum (INIT, RUN);
  - the function init_pattern(idx, DEPTH, DATA_WIDTH);
  - the default parameter constants.
- Sub-module dmem_init_seq holds the FSM and IDX_W-bit counter.
  - Outputs: init_we, init_idx, init_data, ready.
  - The top level muxes the init port against the user port into the array.

## Test plan
- Reset 1 cycle, then idle:
  - ready rises exactly 32 cycles after release.
  - Reads return: addr 5 → 0x05, addr 16 → 0x00, addr 17 → 0xFF, addr 31 → 0xF1.
- RUN: write addr 3 = 0xA5, read addr 3 next cycle → data_outputs = 0xA5 one cycle after the read strobe. data_outputs holds 0xA5 while read = 0.
- Same-cycle write+read addr 7 with data 0x3C → data_outputs = 0x3C after that edge (write-first).
- Aliasing: write address 0x23 = 0x11, read address 0x03 → 0x11.
- Write addr 2 = 0x77 during INIT cycle 5:
  - write_dropped pulses once.
  - After ready, read addr 2 → 0x02.
- Reset re-asserted at INIT cycle 10:
  - ready stays 0.
  - Ready rises 32 cycles after the second release.
- Reset in RUN after writing addr 0 = 0xEE → after re-init, read addr 0 → 0x00.
